// File: rtl/mem_port_arbiter.sv
// Shares one single-port RAM between instruction fetch and load/store; data wins contention
// except when fetch has lost STARVE_MAX contested cycles in a row. Reads return 1 cycle after grant.
module mem_port_arbiter #(
    parameter int ADDR_W     = 16,
    parameter int DATA_W     = 32,
    parameter int STARVE_MAX = 3
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              f_req,
    input  logic [ADDR_W-1:0] f_addr,
    output logic              f_gnt,
    output logic              f_rvalid,
    output logic [DATA_W-1:0] f_rdata,
    input  logic              d_req,
    input  logic              d_we,
    input  logic [ADDR_W-1:0] d_addr,
    input  logic [DATA_W-1:0] d_wdata,
    output logic              d_gnt,
    output logic              d_rvalid,
    output logic [DATA_W-1:0] d_rdata,
    output logic              ram_en,
    output logic              ram_we,
    output logic [ADDR_W-1:0] ram_addr,
    output logic [DATA_W-1:0] ram_wdata,
    input  logic [DATA_W-1:0] ram_rdata,
    output logic [15:0]       conflict_cnt
);

    localparam int SW = (STARVE_MAX < 1) ? 1 : $clog2(STARVE_MAX + 1);
    localparam logic [SW-1:0] STARVE_LIM = SW'(STARVE_MAX);

    typedef enum logic [1:0] {IDLE, RD_F, RD_D} state_t;

    state_t        state, state_nxt;
    logic [SW-1:0] starve_cnt;
    logic          contested;
    logic          starve_hit;

    assign contested  = f_req & d_req;
    assign starve_hit = (starve_cnt == STARVE_LIM);

    // Grants are forced low during reset so nothing reaches the RAM regardless of requests.
    always_comb begin
        f_gnt = 1'b0;
        d_gnt = 1'b0;
        if (!reset) begin
            if (f_req && (!d_req || starve_hit)) begin
                f_gnt = 1'b1;
            end else if (d_req) begin
                d_gnt = 1'b1;
            end
        end
    end

    always_comb begin
        ram_en    = f_gnt | d_gnt;
        ram_we    = 1'b0;
        ram_addr  = '0;
        ram_wdata = '0;
        if (f_gnt) begin
            ram_addr = f_addr;
        end else if (d_gnt) begin
            ram_we    = d_we;
            ram_addr  = d_addr;
            ram_wdata = d_wdata;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            starve_cnt   <= '0;
            conflict_cnt <= '0;
        end else begin
            if (f_gnt) begin
                starve_cnt <= '0;
            end else if (contested && d_gnt && !starve_hit) begin
                starve_cnt <= starve_cnt + 1'b1;
            end
            if (contested && (conflict_cnt != 16'hFFFF)) begin
                conflict_cnt <= conflict_cnt + 16'd1;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Response tracking: re-evaluated every cycle, so a new grant overlaps the previous response.
    always_comb begin
        state_nxt = IDLE;
        f_rvalid  = 1'b0;
        d_rvalid  = 1'b0;
        if (f_gnt) begin
            state_nxt = RD_F;
        end else if (d_gnt && !d_we) begin
            state_nxt = RD_D;
        end
        case (state)
            RD_F:    f_rvalid = 1'b1;
            RD_D:    d_rvalid = 1'b1;
            default: ;
        endcase
    end

    assign f_rdata = ram_rdata;
    assign d_rdata = ram_rdata;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter: inputs change on the falling edge, outputs are sampled 1 ns later.
module tb_mem_port_arbiter;

    logic        clk;
    logic        reset;
    logic        f_req;
    logic [15:0] f_addr;
    logic        f_gnt;
    logic        f_rvalid;
    logic [31:0] f_rdata;
    logic        d_req;
    logic        d_we;
    logic [15:0] d_addr;
    logic [31:0] d_wdata;
    logic        d_gnt;
    logic        d_rvalid;
    logic [31:0] d_rdata;
    logic        ram_en;
    logic        ram_we;
    logic [15:0] ram_addr;
    logic [31:0] ram_wdata;
    logic [31:0] ram_rdata;
    logic [15:0] conflict_cnt;

    int tests;
    int fails;

    mem_port_arbiter #(.ADDR_W(16), .DATA_W(32), .STARVE_MAX(3)) dut (
        .clk(clk), .reset(reset),
        .f_req(f_req), .f_addr(f_addr), .f_gnt(f_gnt), .f_rvalid(f_rvalid), .f_rdata(f_rdata),
        .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
        .d_gnt(d_gnt), .d_rvalid(d_rvalid), .d_rdata(d_rdata),
        .ram_en(ram_en), .ram_we(ram_we), .ram_addr(ram_addr), .ram_wdata(ram_wdata),
        .ram_rdata(ram_rdata), .conflict_cnt(conflict_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic idle_inputs();
        f_req = 1'b0; f_addr = 16'h0; d_req = 1'b0; d_we = 1'b0;
        d_addr = 16'h0; d_wdata = 32'h0;
    endtask

    task automatic pulse_reset();
        @(negedge clk);
        idle_inputs();
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
    endtask

    task automatic test_reset();
        // Requests held high while reset is asserted must not leak through.
        f_req = 1'b1; d_req = 1'b1; f_addr = 16'h1234; d_addr = 16'h5678;
        d_we = 1'b1; d_wdata = 32'hFFFF_FFFF;
        repeat (2) @(negedge clk);
        #1;
        tests++;
        if ({f_gnt, d_gnt, f_rvalid, d_rvalid, ram_en, ram_we} !== 6'b0) begin
            fails++;
            $display("FAIL reset_ctrl: got gnt/rvalid/en/we=%b required 000000",
                     {f_gnt, d_gnt, f_rvalid, d_rvalid, ram_en, ram_we});
        end
        tests++;
        if (ram_addr !== 16'h0 || ram_wdata !== 32'h0 || conflict_cnt !== 16'h0) begin
            fails++;
            $display("FAIL reset_data: addr=%h wdata=%h conflict=%h required all 0",
                     ram_addr, ram_wdata, conflict_cnt);
        end
        @(negedge clk);
        idle_inputs();
        reset = 1'b0;
    endtask

    task automatic test_fetch_read();
        @(negedge clk);
        f_req = 1'b1; f_addr = 16'h0010;
        #1;
        tests++;
        if (f_gnt !== 1'b1 || d_gnt !== 1'b0 || ram_en !== 1'b1 || ram_addr !== 16'h0010
            || ram_we !== 1'b0 || ram_wdata !== 32'h0) begin
            fails++;
            $display("FAIL fetch_grant: f_gnt=%b d_gnt=%b en=%b addr=%h we=%b wdata=%h required 1 0 1 0010 0 0",
                     f_gnt, d_gnt, ram_en, ram_addr, ram_we, ram_wdata);
        end
        @(negedge clk);
        f_req = 1'b0; f_addr = 16'hAAAA; ram_rdata = 32'hDEADBEEF;
        #1;
        tests++;
        if (f_rvalid !== 1'b1 || f_rdata !== 32'hDEADBEEF || d_rvalid !== 1'b0 || ram_en !== 1'b0) begin
            fails++;
            $display("FAIL fetch_resp: f_rvalid=%b f_rdata=%h d_rvalid=%b en=%b required 1 deadbeef 0 0",
                     f_rvalid, f_rdata, d_rvalid, ram_en);
        end
        @(negedge clk);
        #1;
        tests++;
        if (f_rvalid !== 1'b0) begin
            fails++;
            $display("FAIL fetch_pulse: f_rvalid=%b required 0", f_rvalid);
        end
    endtask

    task automatic test_data_write();
        @(negedge clk);
        d_req = 1'b1; d_we = 1'b1; d_addr = 16'h0200; d_wdata = 32'h12345678;
        #1;
        tests++;
        if (d_gnt !== 1'b1 || f_gnt !== 1'b0 || ram_en !== 1'b1 || ram_we !== 1'b1
            || ram_addr !== 16'h0200 || ram_wdata !== 32'h12345678) begin
            fails++;
            $display("FAIL write_grant: d_gnt=%b f_gnt=%b en=%b we=%b addr=%h wdata=%h required 1 0 1 1 0200 12345678",
                     d_gnt, f_gnt, ram_en, ram_we, ram_addr, ram_wdata);
        end
        @(negedge clk);
        idle_inputs();
        #1;
        tests++;
        if (d_rvalid !== 1'b0 || f_rvalid !== 1'b0) begin
            fails++;
            $display("FAIL write_no_rvalid: d_rvalid=%b f_rvalid=%b required 0 0", d_rvalid, f_rvalid);
        end
    endtask

    task automatic test_contention();
        logic [5:0] exp_f;
        exp_f = 6'b001000; // D,D,D,F,D,D
        pulse_reset();
        f_req = 1'b1; d_req = 1'b1; d_we = 1'b0; f_addr = 16'h0100; d_addr = 16'h0300;
        for (int i = 0; i < 6; i++) begin
            #1;
            tests++;
            if (f_gnt !== exp_f[i] || d_gnt !== !exp_f[i]) begin
                fails++;
                $display("FAIL contend_grant[%0d]: f_gnt=%b d_gnt=%b required %b %b",
                         i, f_gnt, d_gnt, exp_f[i], !exp_f[i]);
            end
            if (i > 0) begin
                tests++;
                if (f_rvalid !== exp_f[i-1] || d_rvalid !== !exp_f[i-1]) begin
                    fails++;
                    $display("FAIL contend_rvalid[%0d]: f_rvalid=%b d_rvalid=%b required %b %b",
                             i, f_rvalid, d_rvalid, exp_f[i-1], !exp_f[i-1]);
                end
            end
            @(negedge clk);
        end
        idle_inputs();
        #1;
        tests++;
        if (conflict_cnt !== 16'd6 || d_rvalid !== 1'b1 || f_rvalid !== 1'b0) begin
            fails++;
            $display("FAIL contend_count: conflict=%0d d_rvalid=%b f_rvalid=%b required 6 1 0",
                     conflict_cnt, d_rvalid, f_rvalid);
        end
    endtask

    task automatic test_alternate();
        pulse_reset();
        for (int i = 0; i < 7; i++) begin
            idle_inputs();
            if (i < 6) begin
                if (i % 2 == 0) begin
                    f_req = 1'b1; f_addr = 16'(i);
                end else begin
                    d_req = 1'b1; d_addr = 16'(i);
                end
            end
            ram_rdata = 32'hC000_0000 + 32'(i);
            #1;
            if (i < 6) begin
                tests++;
                if (f_gnt !== (i % 2 == 0) || d_gnt !== (i % 2 == 1) || ram_addr !== 16'(i)) begin
                    fails++;
                    $display("FAIL alt_grant[%0d]: f_gnt=%b d_gnt=%b addr=%h", i, f_gnt, d_gnt, ram_addr);
                end
            end
            tests++;
            if (i == 0) begin
                if (f_rvalid !== 1'b0 || d_rvalid !== 1'b0) begin
                    fails++;
                    $display("FAIL alt_rvalid[0]: f_rvalid=%b d_rvalid=%b required 0 0", f_rvalid, d_rvalid);
                end
            end else if (f_rvalid !== ((i - 1) % 2 == 0) || d_rvalid !== ((i - 1) % 2 == 1)
                         || f_rdata !== 32'hC000_0000 + 32'(i) || d_rdata !== 32'hC000_0000 + 32'(i)) begin
                fails++;
                $display("FAIL alt_rvalid[%0d]: f_rvalid=%b d_rvalid=%b f_rdata=%h d_rdata=%h",
                         i, f_rvalid, d_rvalid, f_rdata, d_rdata);
            end
            @(negedge clk);
        end
    endtask

    task automatic test_reset_inflight();
        pulse_reset();
        d_req = 1'b1; d_we = 1'b0; d_addr = 16'h0044;
        #1;
        tests++;
        if (d_gnt !== 1'b1) begin
            fails++;
            $display("FAIL inflight_grant: d_gnt=%b required 1", d_gnt);
        end
        f_req = 1'b1;
        #1;
        reset = 1'b1;
        #1;
        tests++;
        if ({f_gnt, d_gnt, ram_en, ram_we} !== 4'b0 || ram_addr !== 16'h0) begin
            fails++;
            $display("FAIL inflight_gate: gnt/en/we=%b addr=%h required 0000 0000",
                     {f_gnt, d_gnt, ram_en, ram_we}, ram_addr);
        end
        @(negedge clk);
        #1;
        tests++;
        if (d_rvalid !== 1'b0 || f_rvalid !== 1'b0 || conflict_cnt !== 16'h0 || ram_en !== 1'b0) begin
            fails++;
            $display("FAIL inflight_suppress: d_rvalid=%b f_rvalid=%b conflict=%h en=%b required 0 0 0 0",
                     d_rvalid, f_rvalid, conflict_cnt, ram_en);
        end
        @(negedge clk);
        reset = 1'b0;
        d_req = 1'b0; f_addr = 16'h0077;
        #1;
        tests++;
        if (f_gnt !== 1'b1 || d_rvalid !== 1'b0 || ram_addr !== 16'h0077) begin
            fails++;
            $display("FAIL post_reset_first: f_gnt=%b d_rvalid=%b addr=%h required 1 0 0077",
                     f_gnt, d_rvalid, ram_addr);
        end
        @(negedge clk);
        idle_inputs();
        #1;
        tests++;
        if (d_rvalid !== 1'b0 || f_rvalid !== 1'b1) begin
            fails++;
            $display("FAIL post_reset_resp: d_rvalid=%b f_rvalid=%b required 0 1", d_rvalid, f_rvalid);
        end
    endtask

    task automatic test_saturation();
        pulse_reset();
        f_req = 1'b1; d_req = 1'b1;
        repeat (65534) @(negedge clk);
        #1;
        tests++;
        if (conflict_cnt !== 16'hFFFE) begin
            fails++;
            $display("FAIL sat_before: conflict=%h required fffe", conflict_cnt);
        end
        @(negedge clk);
        #1;
        tests++;
        if (conflict_cnt !== 16'hFFFF) begin
            fails++;
            $display("FAIL sat_reach: conflict=%h required ffff", conflict_cnt);
        end
        repeat (70000 - 65535) @(negedge clk);
        #1;
        tests++;
        if (conflict_cnt !== 16'hFFFF) begin
            fails++;
            $display("FAIL sat_hold: conflict=%h required ffff", conflict_cnt);
        end
        idle_inputs();
    endtask

    initial begin
        tests = 0;
        fails = 0;
        reset = 1'b1;
        ram_rdata = 32'h0;
        idle_inputs();
        test_reset();
        test_fetch_read();
        test_data_write();
        test_contention();
        test_alternate();
        test_reset_inflight();
        test_saturation();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/mem_port_arbiter.md
MEM_PORT_ARBITER -- requirements
Module: mem_port_arbiter

Interface
REQ-001 Parameter ADDR_W, default 16, address width of the shared RAM port.
REQ-002 Parameter DATA_W, default 32, data width of the shared RAM port.
REQ-003 Parameter STARVE_MAX, default 3, max consecutive contested data grants before fetch is forced through.
REQ-004 clk  input  1  single clock; all state changes on rising edge.
REQ-005 reset  input  1  asynchronous, active-high reset.
REQ-006 f_req  input  1  fetch unit requests an instruction read.
REQ-007 f_addr  input  ADDR_W  fetch read address.
REQ-008 f_gnt  output  1  fetch request accepted this cycle.
REQ-009 f_rvalid  output  1  fetch read data valid, one-cycle pulse.
REQ-010 f_rdata  output  DATA_W  fetch read data.
REQ-011 d_req  input  1  load/store unit requests an access.
REQ-012 d_we  input  1  1 = write, 0 = read.
REQ-013 d_addr  input  ADDR_W  data access address.
REQ-014 d_wdata  input  DATA_W  store data.
REQ-015 d_gnt  output  1  data request accepted this cycle.
REQ-016 d_rvalid  output  1  load data valid, one-cycle pulse.
REQ-017 d_rdata  output  DATA_W  load data.
REQ-018 ram_en  output  1  RAM access strobe.
REQ-019 ram_we  output  1  RAM write enable.
REQ-020 ram_addr  output  ADDR_W  RAM address.
REQ-021 ram_wdata  output  DATA_W  RAM write data.
REQ-022 ram_rdata  input  DATA_W  RAM read data, valid one cycle after a read strobe.
REQ-023 conflict_cnt  output  16  saturating count of contested cycles.

Function
REQ-024 Grant combinational in request cycle; at most one of f_gnt/d_gnt high per cycle.
REQ-025 Single requester: always granted. Both: d_gnt unless starve_cnt == STARVE_MAX, then f_gnt.
REQ-026 Internal starve_cnt (width ceil(log2(STARVE_MAX+1))): +1 on each contested cycle granted to data, saturating at STARVE_MAX; cleared on any f_gnt; otherwise holds.
REQ-027 ram_en = f_gnt | d_gnt; ram_addr/ram_we/ram_wdata from granted requester; fetch grant drives ram_we=0, ram_wdata=0.
REQ-028 No grant: ram_en, ram_we, ram_addr, ram_wdata all 0.
REQ-029 Response FSM states IDLE, RD_F, RD_D: f_gnt -> RD_F; d_gnt & ~d_we -> RD_D; no grant or data write -> IDLE; evaluated every cycle from any state.
REQ-030 In RD_F: f_rvalid=1; in RD_D: d_rvalid=1; read latency grant-to-rvalid exactly 1 cycle.
REQ-031 f_rdata and d_rdata = ram_rdata combinationally; meaningful only with respective rvalid.
REQ-032 Back-to-back grants every cycle allowed; a new grant coincides with the previous response without stall.
REQ-033 Writes produce no rvalid; write complete in its grant cycle.
REQ-034 Requesters hold req/addr/we/wdata until gnt; arbiter uses inputs only in grant cycle, ignores them otherwise.
REQ-035 conflict_cnt +1 each cycle f_req & d_req both high; saturates at 16'hFFFF; cleared only by reset.

Reset
REQ-036 While reset high: FSM=IDLE, starve_cnt=0, conflict_cnt=0, all grants, rvalids and ram_* outputs 0, regardless of requests.
REQ-037 Reset asserted with a read in flight: its rvalid is suppressed and never issued after reset deasserts.
REQ-038 First grant possible in the first clock edge cycle after reset deasserts.

Verification
REQ-039 f_req only, f_addr=0x0010, ram_rdata=0xDEADBEEF next cycle -> f_gnt same cycle, ram_en=1, ram_addr=0x0010, f_rvalid=1 with f_rdata=0xDEADBEEF next cycle.
REQ-040 d_req, d_we=1, d_addr=0x0200, d_wdata=0x12345678 -> d_gnt, ram_we=1, ram_wdata=0x12345678; no d_rvalid following.
REQ-041 f_req and d_req (reads) held high 6 cycles, STARVE_MAX=3 -> grant sequence D,D,D,F,D,D; conflict_cnt=6.
REQ-042 Alternating fetch read/data read every cycle -> f_rvalid, d_rvalid alternate, each exactly 1 cycle after its grant, never both high.
REQ-043 Data read granted, reset pulsed before next edge -> no d_rvalid; all outputs 0; conflict_cnt=0.
REQ-044 Both requests held 70000 cycles -> conflict_cnt saturates at 0xFFFF and stays.
